// File: rtl/vid_pkg.sv
// Shared encodings for the video mode controller: output modes, FSM states
// and the default converter latency.
package vid_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_YCBCR  = 2'd1;
    localparam logic [1:0] MODE_LUMA   = 2'd2;

    localparam int CONV_LAT_DEF = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    // The unused encoding 3 is folded onto bypass.
    function automatic logic [1:0] map_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? MODE_BYPASS : mode;
    endfunction

endpackage

// File: rtl/vid_geom_meter.sv
// Video timing tracker: frame/line edge detection, pixel/line coordinates,
// geometry measurement and the lock state machine.
module vid_geom_meter
    import vid_pkg::*;
#(
    parameter int   PIX_W  = 12,
    parameter int   LINE_W = 12,
    parameter int   FRM_W  = 16,
    parameter logic VS_POL = 1'b1
) (
    input  logic              pixelclk,
    input  logic              rst_n,
    input  logic              i_vsync,
    input  logic              i_de,
    output logic              o_fs,
    output logic [PIX_W-1:0]  o_x,
    output logic [LINE_W-1:0] o_y,
    output logic [PIX_W-1:0]  o_width,
    output logic [LINE_W-1:0] o_height,
    output logic [FRM_W-1:0]  o_frame_cnt,
    output logic              o_locked,
    output logic              o_lock_err
);

    logic              r_vs_q, r_vs_qq, r_de_q, r_de_qq;
    logic [PIX_W-1:0]  r_x, r_wcand, r_width;
    logic [LINE_W-1:0] r_y, r_height;
    logic [FRM_W-1:0]  r_frame_cnt;
    logic [1:0]        r_state;
    logic              r_have_w, r_mism, r_locked, r_lock_err;

    logic              w_fs, w_le, w_line_bad, w_mism;
    logic [PIX_W-1:0]  w_len;
    logic [LINE_W-1:0] w_lines;

    assign w_fs    = (r_vs_q == VS_POL) && (r_vs_qq != VS_POL);
    assign w_le    = r_de_qq && !r_de_q;
    // r_x holds the last pixel index when the line end is seen
    assign w_len   = r_x + 1'b1;
    assign w_lines = r_y + {{(LINE_W-1){1'b0}}, w_le};

    assign w_line_bad = w_le && ((r_state == S_MEAS) ? (r_have_w && (w_len != r_wcand))
                                                     : (w_len != r_width));
    assign w_mism     = r_mism || w_line_bad;

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q      <= 1'b0;
            r_vs_qq     <= 1'b0;
            r_de_q      <= 1'b0;
            r_de_qq     <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_wcand     <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_frame_cnt <= '0;
            r_state     <= S_IDLE;
            r_have_w    <= 1'b0;
            r_mism      <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_err  <= 1'b0;
        end else begin
            r_vs_q     <= i_vsync;
            r_vs_qq    <= r_vs_q;
            r_de_q     <= i_de;
            r_de_qq    <= r_de_q;
            r_lock_err <= 1'b0;

            if (w_fs) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (w_le) begin
                r_x <= '0;
            end else if (r_de_q) begin
                r_x <= r_de_qq ? (r_x + 1'b1) : '0;
            end

            if (w_fs) begin
                r_y <= '0;
            end else if (w_le) begin
                r_y <= r_y + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fs) begin
                        r_state  <= S_MEAS;
                        r_have_w <= 1'b0;
                        r_mism   <= 1'b0;
                    end
                end
                S_MEAS: begin
                    if (w_fs) begin
                        if ((r_have_w || w_le) && (w_lines != '0) && !w_mism) begin
                            r_width  <= r_have_w ? r_wcand : w_len;
                            r_height <= w_lines;
                            r_locked <= 1'b1;
                            r_state  <= S_LOCK;
                        end
                        r_have_w <= 1'b0;
                        r_mism   <= 1'b0;
                    end else if (w_le) begin
                        if (!r_have_w) begin
                            r_wcand  <= w_len;
                            r_have_w <= 1'b1;
                        end else if (w_line_bad) begin
                            r_mism <= 1'b1;
                        end
                    end
                end
                S_LOCK: begin
                    if (w_fs) begin
                        if (w_mism || (w_lines != r_height)) begin
                            r_locked   <= 1'b0;
                            r_lock_err <= 1'b1;
                            r_state    <= S_MEAS;
                            r_have_w   <= 1'b0;
                        end
                        r_mism <= 1'b0;
                    end else if (w_line_bad) begin
                        r_mism <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fs        = w_fs;
    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_width     = r_width;
    assign o_height    = r_height;
    assign o_frame_cnt = r_frame_cnt;
    assign o_locked    = r_locked;
    assign o_lock_err  = r_lock_err;

endmodule

// File: rtl/ycbcr_mode_ctrl.sv
// Frame-level controller for the RGB->YCbCr path: applies mode changes on
// frame starts and delays the mode select to match the converter latency.
module ycbcr_mode_ctrl
    import vid_pkg::*;
#(
    parameter int   CONV_LAT = CONV_LAT_DEF,
    parameter int   PIX_W    = 12,
    parameter int   LINE_W   = 12,
    parameter int   FRM_W    = 16,
    parameter logic VS_POL   = 1'b1
) (
    input  logic              pixelclk,
    input  logic              rst_n,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_de,
    input  logic              cfg_req,
    input  logic [1:0]        cfg_mode,
    output logic              cfg_busy,
    output logic              cfg_ack,
    output logic [1:0]        o_mode,
    output logic [1:0]        o_mode_dly,
    output logic              o_conv_en,
    output logic [PIX_W-1:0]  o_x,
    output logic [LINE_W-1:0] o_y,
    output logic [PIX_W-1:0]  o_width,
    output logic [LINE_W-1:0] o_height,
    output logic [FRM_W-1:0]  o_frame_cnt,
    output logic              o_locked,
    output logic              o_lock_err
);

    logic       w_fs;
    logic       w_hsync_unused;
    logic [1:0] r_mode, r_pend;
    logic       r_busy, r_ack;
    logic [1:0] w_tap [CONV_LAT+1];

    assign w_hsync_unused = i_hsync;

    vid_geom_meter #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W),
        .FRM_W  (FRM_W),
        .VS_POL (VS_POL)
    ) u_geom (
        .pixelclk    (pixelclk),
        .rst_n       (rst_n),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .o_fs        (w_fs),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_width     (o_width),
        .o_height    (o_height),
        .o_frame_cnt (o_frame_cnt),
        .o_locked    (o_locked),
        .o_lock_err  (o_lock_err)
    );

    // A request landing on the fs cycle is latched after the apply, so it
    // waits for the following frame start.
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_BYPASS;
            r_pend <= MODE_BYPASS;
            r_busy <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_fs && r_busy) begin
                r_mode <= r_pend;
                r_ack  <= 1'b1;
                r_busy <= 1'b0;
            end
            if (cfg_req) begin
                r_pend <= map_mode(cfg_mode);
                r_busy <= 1'b1;
            end
        end
    end

    assign w_tap[0] = r_mode;

    generate
        for (genvar gi = 0; gi < CONV_LAT; gi++) begin : g_dly
            logic [1:0] r_stage;
            always_ff @(posedge pixelclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= MODE_BYPASS;
                end else begin
                    r_stage <= w_tap[gi];
                end
            end
            assign w_tap[gi+1] = r_stage;
        end
    endgenerate

    assign o_mode_dly = w_tap[CONV_LAT];
    assign o_mode     = r_mode;
    assign o_conv_en  = (r_mode != MODE_BYPASS);
    assign cfg_busy   = r_busy;
    assign cfg_ack    = r_ack;

endmodule

// File: tb/tb_ycbcr_mode_ctrl.sv
// Frame-table bench for ycbcr_mode_ctrl with an ack scoreboard; a second
// instance with a 2-bit frame counter checks wrap-around.
module tb_ycbcr_mode_ctrl;

    localparam int PIX_W  = 12;
    localparam int LINE_W = 12;
    localparam int FRM_W  = 16;

    logic              pixelclk = 1'b0;
    logic              rst_n, i_hsync, i_vsync, i_de, cfg_req;
    logic [1:0]        cfg_mode;
    logic              cfg_busy, cfg_ack, o_conv_en, o_locked, o_lock_err;
    logic [1:0]        o_mode, o_mode_dly;
    logic [PIX_W-1:0]  o_x, o_width;
    logic [LINE_W-1:0] o_y, o_height;
    logic [FRM_W-1:0]  o_frame_cnt;

    logic              d2_busy, d2_ack, d2_conv_en, d2_locked, d2_lock_err;
    logic [1:0]        d2_mode, d2_mode_dly;
    logic [PIX_W-1:0]  d2_x, d2_width;
    logic [LINE_W-1:0] d2_y, d2_height;
    logic [1:0]        d2_frame_cnt;

    always #5 pixelclk = ~pixelclk;

    ycbcr_mode_ctrl #(.CONV_LAT(3), .PIX_W(PIX_W), .LINE_W(LINE_W), .FRM_W(FRM_W), .VS_POL(1'b1)) dut (
        .pixelclk(pixelclk), .rst_n(rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .cfg_req(cfg_req), .cfg_mode(cfg_mode), .cfg_busy(cfg_busy), .cfg_ack(cfg_ack),
        .o_mode(o_mode), .o_mode_dly(o_mode_dly), .o_conv_en(o_conv_en), .o_x(o_x), .o_y(o_y),
        .o_width(o_width), .o_height(o_height), .o_frame_cnt(o_frame_cnt),
        .o_locked(o_locked), .o_lock_err(o_lock_err)
    );

    ycbcr_mode_ctrl #(.CONV_LAT(3), .PIX_W(PIX_W), .LINE_W(LINE_W), .FRM_W(2), .VS_POL(1'b1)) dut2 (
        .pixelclk(pixelclk), .rst_n(rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .cfg_req(cfg_req), .cfg_mode(cfg_mode), .cfg_busy(d2_busy), .cfg_ack(d2_ack),
        .o_mode(d2_mode), .o_mode_dly(d2_mode_dly), .o_conv_en(d2_conv_en), .o_x(d2_x), .o_y(d2_y),
        .o_width(d2_width), .o_height(d2_height), .o_frame_cnt(d2_frame_cnt),
        .o_locked(d2_locked), .o_lock_err(d2_lock_err)
    );

    typedef struct {
        int len;   // pixels per line
        int bad;   // if >0, length of line 2 instead
        int rfs;   // request mode driven on the fs cycle (-1 none)
        int r1;    // request after line 0 (-1 none)
        int r2;    // request after line 2 (-1 none)
        bit xy;    // check x/y coordinates in this frame
        bit elk;   // expected o_locked after this frame's fs
        bit eer;   // expected o_lock_err pulse at this fs
        bit eak;   // expected cfg_ack at this fs
        int emd;   // expected o_mode after this fs
    } vec_t;

    vec_t tbl [12];
    vec_t post [5];

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;
    int cur_mode = 0;
    int sb_q [$];
    bit sb_busy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // One cycle; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        int exp_m;
        @(posedge pixelclk);
        #1;
        if (cfg_ack) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", cfg_ack, 0);
            end else begin
                exp_m = sb_q.pop_front();
                sb_busy = 1'b0;
                chk("ack_mode", o_mode, exp_m);
            end
        end
        if (o_lock_err) err_pulses++;
    endtask

    task automatic sb_push(input int m);
        int mm;
        mm = (m == 3) ? 0 : m;
        if (sb_busy) begin
            sb_q[sb_q.size()-1] = mm;
        end else begin
            sb_q.push_back(mm);
            sb_busy = 1'b1;
        end
    endtask

    task automatic request(input int m);
        cfg_req = 1'b1;
        cfg_mode = 2'(m);
        sb_push(m);
        tick();
        cfg_req = 1'b0;
        chk("req_busy", cfg_busy, 1);
    endtask

    task automatic run_frame(input vec_t v, input int fcnt);
        int len;
        i_vsync = 1'b1;
        tick();
        if (v.rfs >= 0) begin
            cfg_req = 1'b1;
            cfg_mode = 2'(v.rfs);
            sb_push(v.rfs);
        end
        tick();
        cfg_req = 1'b0;
        i_vsync = 1'b0;
        chk("fs_ack", cfg_ack, int'(v.eak));
        chk("fs_mode", o_mode, v.emd);
        chk("fs_conv_en", o_conv_en, int'(v.emd != 0));
        chk("fs_locked", o_locked, int'(v.elk));
        chk("fs_lock_err", o_lock_err, int'(v.eer));
        chk("fs_frame_cnt", o_frame_cnt, fcnt % 65536);
        chk("fs_frame_cnt_w2", d2_frame_cnt, fcnt % 4);
        chk("fs_mode_dly_hold", o_mode_dly, cur_mode);
        if (v.elk) begin
            chk("fs_width", o_width, 8);
            chk("fs_height", o_height, 4);
        end
        if (v.rfs >= 0) chk("fs_req_busy", cfg_busy, 1);
        if (v.xy) chk("fs_y_clear", o_y, 0);
        tick();
        chk("ack_one_cycle", cfg_ack, 0);
        chk("lock_err_one_cycle", o_lock_err, 0);
        tick();
        chk("mode_dly_lat2", o_mode_dly, cur_mode);
        tick();
        chk("mode_dly_lat3", o_mode_dly, v.emd);
        $display("frame %0d: mode=%0d dly=%0d locked=%0d w=%0d h=%0d", fcnt, o_mode, o_mode_dly, o_locked, o_width, o_height);
        cur_mode = v.emd;
        tick();
        tick();
        for (int l = 0; l < 4; l++) begin
            len = (l == 2 && v.bad > 0) ? v.bad : v.len;
            for (int p = 0; p < len; p++) begin
                i_de = 1'b1;
                i_hsync = 1'b0;
                tick();
                if (v.xy && p > 0) begin
                    chk("x_in_line", o_x, p - 1);
                    chk("y_in_line", o_y, l);
                end
            end
            i_de = 1'b0;
            i_hsync = 1'b1;
            tick();
            if (v.xy) chk("x_last", o_x, len - 1);
            tick();
            if (v.xy) begin
                chk("x_clear", o_x, 0);
                chk("y_incr", o_y, l + 1);
            end
            tick();
            tick();
            if (l == 0 && v.r1 >= 0) request(v.r1);
            if (l == 2 && v.r2 >= 0) request(v.r2);
        end
        chk("frame_busy", cfg_busy, int'(v.rfs >= 0 || v.r1 >= 0 || v.r2 >= 0));
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //             len bad rfs r1  r2 xy lk er ak md
        tbl[0]  = '{8, 0, -1, -1, -1, 1, 0, 0, 0, 0};
        tbl[1]  = '{8, 0, -1, -1, -1, 0, 1, 0, 0, 0};
        tbl[2]  = '{8, 0, -1,  1, -1, 0, 1, 0, 0, 0};
        tbl[3]  = '{8, 0, -1,  2,  0, 1, 1, 0, 1, 1};
        tbl[4]  = '{8, 7, -1, -1, -1, 0, 1, 0, 1, 0};
        tbl[5]  = '{8, 0, -1, -1, -1, 0, 0, 1, 0, 0};
        tbl[6]  = '{8, 0, -1,  1, -1, 0, 1, 0, 0, 0};
        tbl[7]  = '{8, 0, -1, -1, -1, 0, 1, 0, 1, 1};
        tbl[8]  = '{8, 0,  2, -1, -1, 0, 1, 0, 0, 1};
        tbl[9]  = '{8, 0, -1,  3, -1, 1, 1, 0, 1, 2};
        tbl[10] = '{8, 0, -1,  2, -1, 0, 1, 0, 1, 0};
        tbl[11] = '{8, 0, -1, -1, -1, 0, 1, 0, 1, 2};
        post[0] = '{8, 0, -1, -1, -1, 1, 0, 0, 0, 0};
        post[1] = '{8, 0, -1, -1, -1, 0, 1, 0, 0, 0};
        post[2] = '{8, 0, -1, -1, -1, 0, 1, 0, 0, 0};
        post[3] = '{8, 0, -1, -1, -1, 0, 1, 0, 0, 0};
        post[4] = '{8, 0, -1, -1, -1, 1, 1, 0, 0, 0};

        rst_n = 1'b0;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de = 1'b0;
        cfg_req = 1'b0;
        cfg_mode = 2'd0;
        repeat (3) tick();
        chk("rst_mode", o_mode, 0);
        chk("rst_mode_dly", o_mode_dly, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        chk("rst_width", o_width, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i], i + 1);
        end

        // Reset in the middle of a line with a request pending.
        i_vsync = 1'b1;
        tick();
        tick();
        i_vsync = 1'b0;
        chk("b_frame_cnt", o_frame_cnt, 13);
        repeat (5) tick();
        i_de = 1'b1;
        repeat (3) tick();
        chk("b_mode_before", o_mode, 2);
        request(1);
        rst_n = 1'b0;
        #1;
        chk("arst_mode", o_mode, 0);
        chk("arst_mode_dly", o_mode_dly, 0);
        chk("arst_conv_en", o_conv_en, 0);
        chk("arst_busy", cfg_busy, 0);
        chk("arst_ack", cfg_ack, 0);
        chk("arst_x", o_x, 0);
        chk("arst_y", o_y, 0);
        chk("arst_width", o_width, 0);
        chk("arst_height", o_height, 0);
        chk("arst_frame_cnt", o_frame_cnt, 0);
        chk("arst_locked", o_locked, 0);
        chk("arst_frame_cnt_w2", d2_frame_cnt, 0);
        sb_q.delete();
        sb_busy = 1'b0;
        i_de = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cur_mode = 0;
        repeat (3) tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(post[i], i + 1);
        end

        chk("lock_err_pulses", err_pulses, 1);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
